ex_mem_skid: RTL and testbench
==============================

Name: ex_mem_skid

Overview:
- EX/MEM pipeline boundary of the pipelined CPU.
- Captures EX results: ALU address/result, store data, store enable, writeback select, pc+4, destination register and RF write enable. Presents them to the memory/writeback stage through a valid/ready handshake.
- Two-entry skid buffer, so EX never sees a combinational path from the memory stage's ready.
- Provides synchronous flush, outputs qualified by valid, and a saturating backpressure counter.

Parameters:
- XLEN, 32, datapath width of alu, rD2, pc4.
- RA_W, 5, register-file address width.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of all held entries (branch/jump redirect)
- in_valid  in  1  EX offers an instruction
- in_ready  out  1  buffer can accept (registered, = !skid_valid)
- in_alu  in  XLEN  ALU result / memory address
- in_rD2  in  XLEN  store data
- in_dram_we  in  1  store enable
- in_wd_sel  in  2  writeback source select
- in_pc4  in  XLEN  pc+4
- in_rd  in  RA_W  destination register
- in_rf_we  in  1  register-file write enable
- out_valid  out  1  head entry valid
- out_ready  in  1  memory stage consumes head
- alu, rD2, pc4  out  XLEN  head entry fields
- wd_sel  out  2  head entry field
- rd  out  RA_W  head entry field
- dram_we  out  1  head dram_we AND out_valid
- rf_we  out  1  head rf_we AND out_valid
- stall_cnt  out  CNT_W  cycles with out_valid && !out_ready, saturating
- fwd_valid  out  1  forwarding tap, see Optional Feature
- fwd_rd  out  RA_W  forwarding tap
- fwd_data  out  XLEN  forwarding tap

Behaviour:
- Storage: head register (drives outputs) and skid register, each with its own valid bit. in_fire = in_valid && in_ready. out_fire = out_valid && out_ready.
- Reset (rst_n low, asynchronous): both valid bits 0. All data registers 0. stall_cnt 0. Therefore out_valid=0, dram_we=0, rf_we=0, in_ready=1.
- States, encoded by {skid_valid, head_valid}:
  - EMPTY: in_fire loads head, go to ONE. Otherwise stay.
  - ONE, in_fire and out_fire: head loads input, stay ONE.
  - ONE, in_fire only: skid loads input, go to FULL.
  - ONE, out_fire only: go to EMPTY.
  - ONE, neither: hold.
  - FULL: in_ready=0. out_fire moves head<=skid, go to ONE. Otherwise hold.
- Latency: 1 cycle from in_fire to out_valid when EMPTY. Order is strictly FIFO.
- Throughput: one instruction per cycle while out_ready=1.
- Flush has the highest priority:
  - Next state is EMPTY and both valid bits clear.
  - An in_fire in the same cycle is discarded.
  - An out_fire in the same cycle still counts as consumed by downstream.
  - Data registers are not cleared, but dram_we/rf_we go low because they are valid-qualified.
- Held entries never change while !out_ready: alu, rD2, dram_we etc. stay stable until out_fire.
- dram_we is asserted only for a valid head, so a flushed store never writes memory.
- stall_cnt increments when out_valid && !out_ready, saturates at all-ones, clears only on reset.
- Reset asserted mid-transfer: entries are lost and in_ready returns to 1 immediately (asynchronously).

Optional Feature:
- Macro EX_MEM_FWD_EN.
- Defined:
  - fwd_valid = out_valid && rf_we && (rd != 0) && (wd_sel selects ALU result).
  - fwd_rd = rd, fwd_data = alu.
  - Feeds the EX forwarding mux. Loads and pc+4 selects are not forwardable, so fwd_valid=0 for them.
- Undefined: fwd_valid, fwd_rd and fwd_data are tied to 0 and no forwarding logic is synthesized.

Test Plan:
- Reset then single push: in_alu=0x1000, in_rf_we=1, rd=5, out_ready=1 -> out_valid=1 next cycle with alu=0x1000, rf_we=1. Following cycle out_valid=0.
- Backpressure: out_ready=0, push A=0x10 then B=0x20 -> in_ready=0 after B, alu holds 0x10, stall_cnt counts 1,2,3… Raise out_ready -> 0x10 then 0x20 in order. No third entry is accepted while FULL.
- Streaming: 8 back-to-back pushes 0x0..0x7 with out_ready=1 -> 8 outputs on consecutive cycles in order, in_ready stays 1.
- Flush with store: head holds dram_we=1, out_ready=0, skid full. Assert flush together with a new in_valid -> next cycle out_valid=0, dram_we=0, in_ready=1, input dropped.
- Async reset mid-FULL: drop rst_n between clock edges -> out_valid and dram_we go 0 immediately, stall_cnt=0.
- EX_MEM_FWD_EN defined:
  - head rd=3, rf_we=1, ALU select, alu=0xABCD -> fwd_valid=1, fwd_rd=3, fwd_data=0xABCD.
  - Same with rd=0 -> fwd_valid=0.
  - Macro undefined -> fwd_* always 0.

Source files
------------

// File: rtl/ex_mem_skid.sv
// EX/MEM pipeline register as a two-entry skid buffer with valid/ready handshake.
// Optional forwarding tap is enabled by defining EX_MEM_FWD_EN.
module ex_mem_skid #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RA_W  = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_alu,
    input  logic [XLEN-1:0]  in_rD2,
    input  logic             in_dram_we,
    input  logic [1:0]       in_wd_sel,
    input  logic [XLEN-1:0]  in_pc4,
    input  logic [RA_W-1:0]  in_rd,
    input  logic             in_rf_we,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  alu,
    output logic [XLEN-1:0]  rD2,
    output logic [XLEN-1:0]  pc4,
    output logic [1:0]       wd_sel,
    output logic [RA_W-1:0]  rd,
    output logic             dram_we,
    output logic             rf_we,

    output logic [CNT_W-1:0] stall_cnt,

    output logic             fwd_valid,
    output logic [RA_W-1:0]  fwd_rd,
    output logic [XLEN-1:0]  fwd_data
);

    // State is simply {skid_valid, head_valid}
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b11;

    typedef struct packed {
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] rD2;
        logic [XLEN-1:0] pc4;
        logic [1:0]      wd_sel;
        logic [RA_W-1:0] rd;
        logic            dram_we;
        logic            rf_we;
    } entry_t;

    entry_t     in_ent;
    entry_t     head_q, head_d;
    entry_t     skid_q, skid_d;
    logic       head_v_q, head_v_d;
    logic       skid_v_q, skid_v_d;
    logic [1:0] state;
    logic       in_fire;
    logic       out_fire;

    assign in_ent = '{
        alu:     in_alu,
        rD2:     in_rD2,
        pc4:     in_pc4,
        wd_sel:  in_wd_sel,
        rd:      in_rd,
        dram_we: in_dram_we,
        rf_we:   in_rf_we
    };

    assign state    = {skid_v_q, head_v_q};
    assign in_ready = !skid_v_q;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = head_v_q && out_ready;

    always_comb begin
        head_d   = head_q;
        skid_d   = skid_q;
        head_v_d = head_v_q;
        skid_v_d = skid_v_q;
        if (flush) begin
            // Data registers keep their contents; only the valid bits are killed.
            head_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        head_d   = in_ent;
                        head_v_d = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        head_d = in_ent;
                    end else if (in_fire) begin
                        skid_d   = in_ent;
                        skid_v_d = 1'b1;
                    end else if (out_fire) begin
                        head_v_d = 1'b0;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        head_d   = skid_q;
                        skid_v_d = 1'b0;
                    end
                end
                default: begin
                    head_v_d = 1'b0;
                    skid_v_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q   <= '0;
            skid_q   <= '0;
            head_v_q <= 1'b0;
            skid_v_q <= 1'b0;
        end else begin
            head_q   <= head_d;
            skid_q   <= skid_d;
            head_v_q <= head_v_d;
            skid_v_q <= skid_v_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (head_v_q && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign out_valid = head_v_q;
    assign alu       = head_q.alu;
    assign rD2       = head_q.rD2;
    assign pc4       = head_q.pc4;
    assign wd_sel    = head_q.wd_sel;
    assign rd        = head_q.rd;
    assign dram_we   = head_q.dram_we && head_v_q;
    assign rf_we     = head_q.rf_we && head_v_q;

`ifdef EX_MEM_FWD_EN
    // wd_sel 2'b00 is the ALU-result writeback; loads and pc+4 are not forwardable
    localparam logic [1:0] WD_ALU = 2'b00;

    assign fwd_valid = head_v_q && head_q.rf_we && (head_q.rd != '0) && (head_q.wd_sel == WD_ALU);
    assign fwd_rd    = head_q.rd;
    assign fwd_data  = head_q.alu;
`else
    assign fwd_valid = 1'b0;
    assign fwd_rd    = '0;
    assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_ex_mem_skid.sv
// Self-checking bench for ex_mem_skid: vector table, hand sequences and an
// occupancy/order scoreboard sampled on the falling edge.
module tb_ex_mem_skid;

    localparam int XLEN  = 32;
    localparam int RA_W  = 5;
    localparam int CNT_W = 4;
`ifdef EX_MEM_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_alu, in_rD2, in_pc4;
    logic             in_dram_we;
    logic [1:0]       in_wd_sel;
    logic [RA_W-1:0]  in_rd;
    logic             in_rf_we;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  alu, rD2, pc4;
    logic [1:0]       wd_sel;
    logic [RA_W-1:0]  rd;
    logic             dram_we, rf_we;
    logic [CNT_W-1:0] stall_cnt;
    logic             fwd_valid;
    logic [RA_W-1:0]  fwd_rd;
    logic [XLEN-1:0]  fwd_data;

    ex_mem_skid #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu(in_alu), .in_rD2(in_rD2), .in_dram_we(in_dram_we),
        .in_wd_sel(in_wd_sel), .in_pc4(in_pc4), .in_rd(in_rd), .in_rf_we(in_rf_we),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu(alu), .rD2(rD2), .pc4(pc4), .wd_sel(wd_sel), .rd(rd),
        .dram_we(dram_we), .rf_we(rf_we), .stall_cnt(stall_cnt),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] rD2;
        logic [31:0] pc4;
        logic [1:0]  wd_sel;
        logic [4:0]  rd;
        logic        dram_we;
        logic        rf_we;
    } ent_t;

    typedef struct {
        logic        iv;
        logic [31:0] a;
        logic        dwe;
        logic        rfwe;
        logic [4:0]  r;
        logic        ordy;
        logic        fl;
        logic        e_ov;
        logic        e_ir;
        logic [31:0] e_alu;
        logic        e_dwe;
        logic        e_rfwe;
        logic [3:0]  e_stall;
    } vec_t;

    ent_t sb[$];
    ent_t got_e, exp_e;
    vec_t vecs[8];
    int   errors = 0;
    int   checks = 0;
    int   pops   = 0;
    int   pops0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] a, input logic dwe, input logic rfwe,
                         input logic [4:0] r, input logic [1:0] wd, input logic ordy, input logic fl);
        in_valid   = iv;
        in_alu     = a;
        in_rD2     = ~a;
        in_pc4     = a + 32'd4;
        in_dram_we = dwe;
        in_rf_we   = rfwe;
        in_rd      = r;
        in_wd_sel  = wd;
        out_ready  = ordy;
        flush      = fl;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Model: queue size is the buffer occupancy, queue order is the output order.
    always @(negedge clk) begin : sb_mon
        bit m_ov;
        bit m_ir;
        if (!rst_n) begin
            sb.delete();
        end else begin
            m_ov = sb.size() > 0;
            m_ir = sb.size() < 2;
            chk("sb_out_valid", {31'd0, out_valid}, {31'd0, m_ov});
            chk("sb_in_ready", {31'd0, in_ready}, {31'd0, m_ir});
            if (m_ov && out_ready) begin
                exp_e = sb.pop_front();
                got_e = '{alu: alu, rD2: rD2, pc4: pc4, wd_sel: wd_sel, rd: rd,
                          dram_we: dram_we, rf_we: rf_we};
                checks++;
                pops++;
                if (got_e !== exp_e) begin
                    errors++;
                    $display("FAIL sb_entry: got 0x%0h expected 0x%0h", got_e, exp_e);
                end
            end
            if (flush) begin
                sb.delete();
            end else if (in_valid && m_ir) begin
                sb.push_back('{alu: in_alu, rD2: in_rD2, pc4: in_pc4, wd_sel: in_wd_sel,
                               rd: in_rd, dram_we: in_dram_we, rf_we: in_rf_we});
            end
        end
    end

    initial begin
        //            iv  a          dwe rfwe rd ordy fl   ov  ir  alu        dwe rfwe stall
        vecs[0] = '{1'b1, 32'h1000, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1000, 1'b0, 1'b1, 4'd0};
        vecs[1] = '{1'b0, 32'h0,    1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,    1'b0, 1'b0, 4'd0};
        vecs[2] = '{1'b1, 32'h10,   1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h10,   1'b0, 1'b1, 4'd0};
        vecs[3] = '{1'b1, 32'h20,   1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10,   1'b0, 1'b1, 4'd1};
        vecs[4] = '{1'b1, 32'h30,   1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10,   1'b0, 1'b1, 4'd2};
        vecs[5] = '{1'b0, 32'h0,    1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10,   1'b0, 1'b1, 4'd3};
        vecs[6] = '{1'b0, 32'h0,    1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h20,   1'b0, 1'b1, 4'd3};
        vecs[7] = '{1'b0, 32'h0,    1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,    1'b0, 1'b0, 4'd3};

        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_dram_we", {31'd0, dram_we}, 32'd0);
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("rst_stall", {28'd0, stall_cnt}, 32'd0);
        chk("rst_fwd_valid", {31'd0, fwd_valid}, 32'd0);

        // single push and backpressure with a rejected third entry
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].iv, vecs[i].a, vecs[i].dwe, vecs[i].rfwe, vecs[i].r, 2'd0,
                  vecs[i].ordy, vecs[i].fl);
            tick();
            chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
            chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].e_ir});
            chk($sformatf("vec%0d_dram_we", i), {31'd0, dram_we}, {31'd0, vecs[i].e_dwe});
            chk($sformatf("vec%0d_rf_we", i), {31'd0, rf_we}, {31'd0, vecs[i].e_rfwe});
            chk($sformatf("vec%0d_stall", i), {28'd0, stall_cnt}, {28'd0, vecs[i].e_stall});
            if (vecs[i].e_ov) chk($sformatf("vec%0d_alu", i), alu, vecs[i].e_alu);
        end

        // streaming
        pops0 = pops;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i, 1'b0, 1'b1, i[4:0], 2'd0, 1'b1, 1'b0);
            tick();
            chk($sformatf("stream%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
            chk($sformatf("stream%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("stream%0d_alu", i), alu, i);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b1, 1'b0);
        tick();
        chk("stream_drained", {31'd0, out_valid}, 32'd0);
        chk("stream_count", pops - pops0, 32'd8);

        // flush with stores held and a simultaneous new input
        drive(1'b1, 32'h40, 1'b1, 1'b0, 5'd1, 2'd0, 1'b0, 1'b0);
        tick();
        chk("flush_head_dwe", {31'd0, dram_we}, 32'd1);
        drive(1'b1, 32'h50, 1'b1, 1'b0, 5'd1, 2'd0, 1'b0, 1'b0);
        tick();
        chk("flush_full", {31'd0, in_ready}, 32'd0);
        drive(1'b1, 32'h60, 1'b1, 1'b0, 5'd1, 2'd0, 1'b0, 1'b1);
        tick();
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_dram_we", {31'd0, dram_we}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        chk("flush_stall", {28'd0, stall_cnt}, 32'd5);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b1, 1'b0);
        tick();
        chk("flush_dropped", {31'd0, out_valid}, 32'd0);

        // asynchronous reset while full
        drive(1'b1, 32'h70, 1'b1, 1'b1, 5'd2, 2'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h80, 1'b1, 1'b1, 5'd2, 2'd0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0);
        chk("pre_arst_dwe", {31'd0, dram_we}, 32'd1);
        chk("pre_arst_full", {31'd0, in_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_dram_we", {31'd0, dram_we}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_stall", {28'd0, stall_cnt}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // stall counter saturation with a held entry
        drive(1'b1, 32'h90, 1'b0, 1'b1, 5'd4, 2'd0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0);
        repeat (15) tick();
        chk("stall_15", {28'd0, stall_cnt}, 32'd15);
        repeat (5) tick();
        chk("stall_sat", {28'd0, stall_cnt}, 32'd15);
        chk("held_alu", alu, 32'h90);
        chk("held_pc4", pc4, 32'h94);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b1, 1'b0);
        tick();
        chk("sat_drained", {31'd0, out_valid}, 32'd0);

        // forwarding tap
        drive(1'b1, 32'hABCD, 1'b0, 1'b1, 5'd3, 2'd0, 1'b0, 1'b0);
        tick();
        chk("fwd_alu_valid", {31'd0, fwd_valid}, {31'd0, FWD});
        chk("fwd_alu_rd", {27'd0, fwd_rd}, FWD ? 32'd3 : 32'd0);
        chk("fwd_alu_data", fwd_data, FWD ? 32'hABCD : 32'd0);
        drive(1'b1, 32'h1234, 1'b0, 1'b1, 5'd0, 2'd0, 1'b1, 1'b0);
        tick();
        chk("fwd_rd0_valid", {31'd0, fwd_valid}, 32'd0);
        chk("fwd_rd0_data", fwd_data, FWD ? 32'h1234 : 32'd0);
        drive(1'b1, 32'h5678, 1'b0, 1'b1, 5'd7, 2'd1, 1'b1, 1'b0);
        tick();
        chk("fwd_load_valid", {31'd0, fwd_valid}, 32'd0);
        chk("fwd_load_rd", {27'd0, fwd_rd}, FWD ? 32'd7 : 32'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b1, 1'b0);
        tick();
        chk("fwd_idle_valid", {31'd0, fwd_valid}, 32'd0);
        chk("final_empty", {31'd0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
